// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared types, frame width helper and register map for spi_cfg_regfile
package spi_cfg_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   localparam int EN_OUT_LO   = 0;
   localparam int EN_OUT_HI   = 1;
   localparam int PWM_MODE_LO = 2;
   localparam int PWM_MODE_HI = 3;
   localparam int PWM_DUTY    = 4;

   function automatic int frame_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_cfg_regfile_sync_edge.sv
// rtl/spi_cfg_regfile_sync_edge.sv - pin synchronizer with reset value and rise/fall pulses
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   input  logic rst_val_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{rst_val_i}};
         prev_q <= rst_val_i;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_cfg_regfile.sv
// rtl/spi_cfg_regfile.sv - SPI mode-0 configuration register bank
// Optional CIPO read-back is built when SPI_READBACK_EN is defined.
module spi_cfg_regfile
   import spi_cfg_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int NUM_REGS    = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sclk,
   input  logic                         copi,
   input  logic                         ncs,
   output logic                         cipo,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          wr_strobe,
   output logic                         frame_err
);

   localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int HDR_W   = 1 + ADDR_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   logic sclk_s, sclk_rise, sclk_fall;
   logic copi_s, copi_rise, copi_fall;
   logic ncs_s, ncs_rise, ncs_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d_i(sclk), .rst_val_i(1'b0),
      .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .d_i(copi), .rst_val_i(1'b0),
      .q_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .d_i(ncs), .rst_val_i(1'b1),
      .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall));

   state_e                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d, cnt_inc;
   logic [FRAME_W-1:0]           shreg_q, shreg_d, shreg_nxt;
   logic [NUM_REGS*DATA_W-1:0]   reg_d;
   logic [NUM_REGS-1:0]          wr_strobe_q, wr_strobe_d;
   logic                         frame_err_q, frame_err_d;
   logic                         wr_rw;
   logic [ADDR_W-1:0]            wr_addr;
   logic [DATA_W-1:0]            wr_data;

   assign shreg_nxt = {shreg_q[FRAME_W-2:0], copi_s};
   assign cnt_inc   = cnt_q + 1'b1;
   assign wr_rw     = shreg_nxt[FRAME_W-1];
   assign wr_addr   = shreg_nxt[DATA_W +: ADDR_W];
   assign wr_data   = shreg_nxt[DATA_W-1:0];

   // ncs rise is checked before sclk rise so a frame ending together with ncs is truncated
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      reg_d       = reg_q;
      wr_strobe_d = '0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (ncs_fall) begin
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (ncs_rise) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else if (sclk_rise) begin
               shreg_d = shreg_nxt;
               cnt_d   = cnt_inc;
               if (cnt_inc == CNT_W'(FRAME_W)) begin
                  state_d = DONE;
                  for (int r = 0; r < NUM_REGS; r++) begin
                     if (wr_rw && wr_addr == ADDR_W'(r)) begin
                        reg_d[r*DATA_W +: DATA_W] = wr_data;
                        wr_strobe_d[r]            = 1'b1;
                     end
                  end
               end
            end
         end
         DONE: begin
            if (ncs_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         reg_q       <= '0;
         wr_strobe_q <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         reg_q       <= reg_d;
         wr_strobe_q <= wr_strobe_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign wr_strobe = wr_strobe_q;
   assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
   logic [DATA_W-2:0] tx_q;
   logic              cipo_q, rd_act_q, tx_skip_q;
   logic [DATA_W-1:0] rd_word;
   logic              load_hdr;

   assign load_hdr = (state_q == SHIFT) && !ncs_rise && sclk_rise && (cnt_inc == CNT_W'(HDR_W));

   always_comb begin
      rd_word = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (shreg_nxt[ADDR_W-1:0] == ADDR_W'(r)) rd_word = reg_q[r*DATA_W +: DATA_W];
      end
   end

   // The sclk fall right after the last header bit is skipped so the MSB is still on cipo
   // when the host samples the first data bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q      <= '0;
         cipo_q    <= 1'b0;
         rd_act_q  <= 1'b0;
         tx_skip_q <= 1'b0;
      end else if (ncs_rise || state_q == IDLE) begin
         cipo_q   <= 1'b0;
         rd_act_q <= 1'b0;
      end else if (load_hdr) begin
         rd_act_q          <= !shreg_nxt[ADDR_W];
         tx_skip_q         <= 1'b1;
         {cipo_q, tx_q}    <= shreg_nxt[ADDR_W] ? '0 : rd_word;
      end else if (rd_act_q && sclk_fall) begin
         if (tx_skip_q) tx_skip_q <= 1'b0;
         else           {cipo_q, tx_q} <= {tx_q, 1'b0};
      end
   end

   assign cipo = cipo_q;

   logic unused_pins;
   assign unused_pins = ^{sclk_s, copi_rise, copi_fall, ncs_s};
`else
   assign cipo = 1'b0;

   logic unused_pins;
   assign unused_pins = ^{sclk_s, sclk_fall, copi_rise, copi_fall, ncs_s, shreg_q[FRAME_W-1]};
`endif

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// tb/tb_spi_cfg_regfile.sv - scoreboard bench for spi_cfg_regfile (default parameters)
module tb_spi_cfg_regfile;

   localparam int H   = 6;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sclk, copi, ncs;
   logic        cipo;
   logic [39:0] reg_q;
   logic [4:0]  wr_strobe;
   logic        frame_err;

   spi_cfg_regfile dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .cipo(cipo), .reg_q(reg_q), .wr_strobe(wr_strobe), .frame_err(frame_err));

   always #5 clk = ~clk;

   typedef struct {
      logic       err;
      logic [4:0] strobe;
      int         addr;
      logic [7:0] data;
   } evt_t;

   evt_t       sb[$];
   logic [7:0] model [5];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc = 0;
   int         last_rise = 0;
   int         last_ncs  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_wr(input int a, input logic [7:0] d);
      evt_t e;
      e.err = 1'b0; e.strobe = 5'(1 << a); e.addr = a; e.data = d;
      sb.push_back(e);
      model[a] = d;
   endtask

   task automatic push_err();
      evt_t e;
      e.err = 1'b1; e.strobe = '0; e.addr = 0; e.data = '0;
      sb.push_back(e);
   endtask

   // mode 0: normal end, 1: ncs rises with the last sclk rise, 2: leave ncs low
   task automatic spi_frame(input logic [15:0] f, input int nbits, input int mode,
                            output logic [7:0] rx);
      rx  = '0;
      ncs = 1'b0;
      wait_clk(H);
      for (int i = 0; i < nbits; i++) begin
         copi = f[15-i];
         wait_clk(H);
         if (i >= 8) rx = {rx[6:0], cipo};
         sclk      = 1'b1;
         last_rise = cyc;
         if (mode == 1 && i == nbits - 1) begin
            ncs      = 1'b1;
            last_ncs = cyc;
         end
         wait_clk(H);
         sclk = 1'b0;
      end
      if (mode == 0) begin
         wait_clk(H);
         ncs      = 1'b1;
         last_ncs = cyc;
      end
      if (mode != 2) wait_clk(3 * H);
   endtask

   task automatic chk_regs(input string tag);
      for (int r = 0; r < 5; r++) chk_eq($sformatf("%s_reg%0d", tag, r), 32'(reg_q[r*8 +: 8]), 32'(model[r]));
   endtask

   always @(negedge clk) begin
      if (rst_n && (wr_strobe != '0 || frame_err)) begin
         if (sb.size() == 0) begin
            chk_eq("unexpected_evt", {26'd0, frame_err, wr_strobe}, 32'd0);
         end else begin
            evt_t e;
            e = sb.pop_front();
            chk_eq("evt_err", 32'(frame_err), 32'(e.err));
            chk_eq("evt_strobe", 32'(wr_strobe), 32'(e.strobe));
            if (!e.err) chk_eq("evt_data", 32'(reg_q[e.addr*8 +: 8]), 32'(e.data));
            chk_eq("evt_latency", 32'(cyc - (e.err ? last_ncs : last_rise)), 32'(LAT));
         end
      end
   end

   initial begin
      logic [7:0] rx;
      for (int r = 0; r < 5; r++) model[r] = '0;
      rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
      wait_clk(3);
      chk_eq("rst_reg_q", 32'(reg_q != '0), 32'd0);
      chk_eq("rst_strobe", 32'(wr_strobe), 32'd0);
      chk_eq("rst_frame_err", 32'(frame_err), 32'd0);
      chk_eq("rst_cipo", 32'(cipo), 32'd0);
      rst_n = 1'b1;
      wait_clk(5);

      push_wr(4, 8'hA5);
      spi_frame(16'h84A5, 16, 0, rx);
      chk_regs("t1");

      push_wr(0, 8'hFF);
      spi_frame(16'h80FF, 16, 0, rx);
      push_wr(1, 8'hF0);
      spi_frame(16'h81F0, 16, 0, rx);
      chk_regs("t2");

      spi_frame(16'h8A11, 16, 0, rx);
      chk_regs("t3");

      push_err();
      spi_frame(16'h8233, 9, 0, rx);
      chk_regs("t4_trunc");
      push_wr(2, 8'h33);
      spi_frame(16'h8233, 16, 0, rx);
      chk_regs("t4_full");

      push_err();
      spi_frame(16'h82EE, 16, 1, rx);
      chk_regs("t4_simul");

      push_wr(4, 8'hA5);
      spi_frame(16'h84A5, 16, 0, rx);
      spi_frame(16'h0400, 16, 0, rx);
`ifdef SPI_READBACK_EN
      chk_eq("t6_readback", 32'(rx), 32'h0000_00A5);
`else
      chk_eq("t6_readback", 32'(rx), 32'd0);
`endif
      chk_regs("t6");

      spi_frame(16'h8377, 10, 2, rx);
      wait_clk(H);
      rst_n = 1'b0;
      wait_clk(2);
      for (int r = 0; r < 5; r++) model[r] = '0;
      chk_eq("t5_rst_reg_q", 32'(reg_q != '0), 32'd0);
      chk_eq("t5_rst_strobe", 32'(wr_strobe), 32'd0);
      chk_eq("t5_rst_frame_err", 32'(frame_err), 32'd0);
      chk_eq("t5_rst_cipo", 32'(cipo), 32'd0);
      ncs  = 1'b1;
      sclk = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(5);
      push_wr(3, 8'h77);
      spi_frame(16'h8377, 16, 0, rx);
      chk_regs("t5");

      wait_clk(10);
      chk_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
